// File: rtl/pipe_latch_chain.sv
// ============================================================================
// Module      : pipe_latch_chain
// Description : Parametrised pipeline-latch chain with per-stage valid bits,
//               stall propagation, bubble insertion, partial flush, and
//               debug cycle/retire counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_latch_chain #(
    parameter int NSTAGES = 5,
    parameter int WIDTH   = 64,
    parameter int DBITS   = 32,
    parameter int SW      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic [NSTAGES-1:0]         stall_req,
    input  logic                       flush_valid,
    input  logic [SW-1:0]              flush_stage,
    output logic [NSTAGES-1:0]         stage_valid,
    output logic [NSTAGES*WIDTH-1:0]   stage_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [DBITS-1:0]           cycle_count,
    output logic [DBITS-1:0]           retire_count
);

    localparam logic [SW-1:0] c_last_stage = SW'(NSTAGES - 1);

    logic [NSTAGES-1:0] w_hold;
    logic [NSTAGES-1:0] w_flush;
    logic [SW-1:0]      w_fs;
    logic               w_retire;

    logic [NSTAGES-1:0] r_valid;
    logic [WIDTH-1:0]   r_data [NSTAGES];
    logic [DBITS-1:0]   r_cycle_count;
    logic [DBITS-1:0]   r_retire_count;

    // A stall at stage k freezes every younger stage behind it.
    generate
        for (genvar k = 0; k < NSTAGES; k++) begin : g_hold
            if (k == NSTAGES - 1) begin : g_top
                assign w_hold[k] = stall_req[k];
            end else begin : g_rest
                assign w_hold[k] = stall_req[k] | w_hold[k+1];
            end
        end
    endgenerate

    assign w_fs = (flush_stage > c_last_stage) ? c_last_stage : flush_stage;

    generate
        for (genvar k = 0; k < NSTAGES; k++) begin : g_flush
            assign w_flush[k] = flush_valid && (SW'(k) <= w_fs);
        end
    endgenerate

    assign in_ready = !reset && !w_hold[0] && !flush_valid;

    generate
        for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_valid[k] <= 1'b0;
                        r_data[k]  <= '0;
                    end else if (w_flush[k]) begin
                        r_valid[k] <= 1'b0;
                    end else if (!w_hold[k]) begin
                        r_valid[k] <= in_valid;
                        r_data[k]  <= in_data;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_valid[k] <= 1'b0;
                        r_data[k]  <= '0;
                    end else if (w_flush[k]) begin
                        r_valid[k] <= 1'b0;
                    end else if (!w_hold[k]) begin
                        // Upstream frozen while this stage drains: insert a bubble.
                        if (w_hold[k-1]) begin
                            r_valid[k] <= 1'b0;
                        end else begin
                            r_valid[k] <= r_valid[k-1];
                            r_data[k]  <= r_data[k-1];
                        end
                    end
                end
            end
            assign stage_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    endgenerate

    // Retire is judged on the pre-flush state of the last latch.
    assign w_retire = r_valid[NSTAGES-1] && !stall_req[NSTAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (w_retire) begin
                r_retire_count <= r_retire_count + 1'b1;
            end
        end
    end

    assign stage_valid  = r_valid;
    assign out_valid    = r_valid[NSTAGES-1];
    assign out_data     = r_data[NSTAGES-1];
    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_latch_chain.sv
// ============================================================================
// Module      : tb_pipe_latch_chain
// Description : Directed and randomized bench for pipe_latch_chain against a
//               slot-shifting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_latch_chain;

    localparam int NSTAGES = 5;
    localparam int WIDTH   = 64;
    localparam int DBITS   = 32;
    localparam int SW      = 3;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic [NSTAGES-1:0]       stall_req;
    logic                     flush_valid;
    logic [SW-1:0]            flush_stage;
    logic [NSTAGES-1:0]       stage_valid;
    logic [NSTAGES*WIDTH-1:0] stage_data;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [DBITS-1:0]         cycle_count;
    logic [DBITS-1:0]         retire_count;

    pipe_latch_chain #(
        .NSTAGES (NSTAGES),
        .WIDTH   (WIDTH),
        .DBITS   (DBITS),
        .SW      (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall_req    (stall_req),
        .flush_valid  (flush_valid),
        .flush_stage  (flush_stage),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: slot contents and counters.
    logic             m_v  [NSTAGES];
    logic [WIDTH-1:0] m_d  [NSTAGES];
    logic [DBITS-1:0] m_cc;
    logic [DBITS-1:0] m_rc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NSTAGES; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
        end
        m_cc = '0;
        m_rc = '0;
    endtask

    // One clock cycle: drive, check in_ready, predict, clock, check state.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic [NSTAGES-1:0] st,
                        input logic fv, input logic [SW-1:0] fsg, input logic rs);
        int               s;
        int               fs;
        logic             nv [NSTAGES];
        logic [WIDTH-1:0] nd [NSTAGES];
        logic             exp_ready;
        @(negedge clk);
        reset       = rs;
        in_valid    = iv;
        in_data     = id;
        stall_req   = st;
        flush_valid = fv;
        flush_stage = fsg;
        #1;
        // Highest stalled slot: everything at or below it stays put.
        s = -1;
        for (int k = 0; k < NSTAGES; k++) if (st[k]) s = k;
        exp_ready = !rs && (s < 0) && !fv;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});

        if (rs) begin
            model_reset();
        end else begin
            if (m_v[NSTAGES-1] && !st[NSTAGES-1]) m_rc = m_rc + 1;
            m_cc = m_cc + 1;
            for (int k = 0; k < NSTAGES; k++) begin
                if (k <= s) begin
                    nv[k] = m_v[k];
                    nd[k] = m_d[k];
                end else if (k == s + 1 && s >= 0) begin
                    nv[k] = 1'b0;
                    nd[k] = m_d[k];
                end else if (k == 0) begin
                    nv[k] = iv;
                    nd[k] = id;
                end else begin
                    nv[k] = m_v[k-1];
                    nd[k] = m_d[k-1];
                end
            end
            fs = (int'(fsg) > NSTAGES - 1) ? NSTAGES - 1 : int'(fsg);
            if (fv) for (int k = 0; k <= fs; k++) nv[k] = 1'b0;
            for (int k = 0; k < NSTAGES; k++) begin
                m_v[k] = nv[k];
                m_d[k] = nd[k];
            end
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < NSTAGES; k++) begin
            chk("stage_valid", {63'd0, stage_valid[k]}, {63'd0, m_v[k]});
            if (m_v[k]) chk("stage_data", stage_data[k*WIDTH +: WIDTH], m_d[k]);
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_v[NSTAGES-1]});
        if (m_v[NSTAGES-1]) chk("out_data", out_data, m_d[NSTAGES-1]);
        chk("cycle_count", {32'd0, cycle_count}, {32'd0, m_cc});
        chk("retire_count", {32'd0, retire_count}, {32'd0, m_rc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0;
        flush_valid = 1'b0; flush_stage = '0;
        model_reset();

        // Reset state
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        chk("rst_valid", {59'd0, stage_valid}, 64'd0);
        chk("rst_cycle", {32'd0, cycle_count}, 64'd0);

        // Single item latency
        step(1'b1, 64'hA1, '0, 1'b0, '0, 1'b0);
        idle(4);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_out_data", out_data, 64'hA1);
        idle(1);
        chk("t1_retire", {32'd0, retire_count}, 64'd1);

        // Stream 1..8 with a 2-cycle stall at latch 2
        for (int i = 1; i <= 8; i++) begin
            if (i == 4 || i == 5) step(1'b1, 64'(i), 5'b00100, 1'b0, '0, 1'b0);
            step(1'b1, 64'(i), '0, 1'b0, '0, 1'b0);
        end
        idle(8);

        // Fill chain 1..5 then partial flush at stage 2 while offering input
        for (int i = 1; i <= 5; i++) step(1'b1, 64'(i), '0, 1'b0, '0, 1'b0);
        step(1'b1, 64'hDEAD, '0, 1'b1, 3'd2, 1'b0);
        chk("t3_valid", {59'd0, stage_valid}, 64'b11000);
        idle(4);

        // Stall with overlapping flush, then clamped flush
        for (int i = 1; i <= 5; i++) step(1'b1, 64'(16 + i), '0, 1'b0, '0, 1'b0);
        step(1'b1, 64'h55, 5'b00010, 1'b1, 3'd3, 1'b0);
        chk("t4_valid", {59'd0, stage_valid}, 64'b10000);
        for (int i = 1; i <= 3; i++) step(1'b1, 64'(32 + i), '0, 1'b0, '0, 1'b0);
        step(1'b1, 64'h66, '0, 1'b1, 3'd7, 1'b0);
        chk("t4_clamp", {59'd0, stage_valid}, 64'd0);

        // Output stall for 3 cycles
        for (int i = 1; i <= 5; i++) step(1'b1, 64'(48 + i), '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h77, 5'b10000, 1'b0, '0, 1'b0);
        chk("t5_out_data", out_data, 64'd49);
        idle(2);

        // Mid-stream reset
        for (int i = 1; i <= 3; i++) step(1'b1, 64'(64 + i), '0, 1'b0, '0, 1'b0);
        step(1'b1, 64'h88, '0, 1'b0, '0, 1'b1);
        chk("t6_retire", {32'd0, retire_count}, 64'd0);
        step(1'b1, 64'h89, '0, 1'b0, '0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [NSTAGES-1:0] st;
            st = '0;
            for (int k = 0; k < NSTAGES; k++) st[k] = ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, st,
                 ($urandom_range(0, 15) == 0), SW'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
